// File: rtl/register_32bit_pkg.sv
// Shared width, word type and reset constant for the register-file data registers.
package register_32bit_pkg;
   localparam int REG_WIDTH = 32;
   typedef logic [REG_WIDTH-1:0] word_t;
   localparam word_t REG_RESET_VALUE = '0;
endpackage

// File: rtl/register_32bit_en_bit.sv
// dff_en_bit: one-bit enable flop with asynchronous active-high reset and per-bit reset value.
module dff_en_bit #(
   parameter logic RESET_BIT = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic q
);

   // Bit storage: reset wins, otherwise capture d when enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= RESET_BIT;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/register_32bit_en.sv
// 32-bit write-enable data register built from independent one-bit flops.
// Optional stored even parity bit when REG32_PARITY_EN is defined.
module register_32bit_en
   import register_32bit_pkg::*;
#(
   parameter int               WIDTH       = REG_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] newdata,
   input  logic             en,
   output logic [WIDTH-1:0] out
`ifdef REG32_PARITY_EN
   ,
   output logic             parity_out
`endif
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_en_bit #(
         .RESET_BIT (RESET_VALUE[i])
      ) u_bit (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .d     (newdata[i]),
         .q     (out[i])
      );
   end

`ifdef REG32_PARITY_EN
   function automatic logic parity_of(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction

   logic parity_s;

   // Parity of the incoming word, captured on the same edge as the data.
   always_comb begin
      parity_s = parity_of(newdata);
   end

   dff_en_bit #(
      .RESET_BIT (parity_of(RESET_VALUE))
   ) u_parity (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (parity_s),
      .q     (parity_out)
   );
`endif

endmodule

// File: tb/tb_register_32bit_en.sv
// Self-checking bench for register_32bit_en: word-level model compared every cycle plus directed literal checks.
module tb_register_32bit_en;

   logic        clk;
   logic        reset;
   logic [31:0] newdata;
   logic        en;
   logic [31:0] out;
   logic        parity_out;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_q;

   register_32bit_en dut (
      .clk        (clk),
      .reset      (reset),
      .newdata    (newdata),
      .en         (en),
      .out        (out)
`ifdef REG32_PARITY_EN
      ,
      .parity_out (parity_out)
`endif
   );

`ifndef REG32_PARITY_EN
   assign parity_out = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Word-level model: whole-word load on enabled edges, cleared by reset at any time.
   always @(posedge clk or posedge reset) begin
      if (reset)
         model_q <= 32'h0;
      else if (en)
         model_q <= newdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model on every falling edge.
   always @(negedge clk) begin
      chk("model_out", out, model_q);
`ifdef REG32_PARITY_EN
      chk("model_parity", {31'h0, parity_out}, {31'h0, 1'($countones(model_q) % 2)});
`endif
   end

   task automatic write_cycle(input logic e, input logic [31:0] d);
      en      = e;
      newdata = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      en      = 1'b0;
      newdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_state", out, 32'h0);
      reset = 1'b0;

      // Async reset mid-cycle.
      write_cycle(1'b1, 32'h000000A0);
      chk("pre_reset_A0", out, 32'h000000A0);
      en = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_immediate", out, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      write_cycle(1'b0, 32'h00000055);
      chk("after_release_hold", out, 32'h0);

      // Write/hold and overwrite with zero.
      write_cycle(1'b1, 32'd32);
      chk("write_32", out, 32'd32);
      write_cycle(1'b0, 32'd32);
      chk("hold_32", out, 32'd32);
      write_cycle(1'b1, 32'd0);
      chk("write_0", out, 32'd0);
      write_cycle(1'b0, 32'd0);
      chk("hold_0", out, 32'd0);

      // Low bit and pattern.
      write_cycle(1'b1, 32'h00000001);
      chk("write_1", out, 32'h00000001);
`ifdef REG32_PARITY_EN
      chk("parity_1", {31'h0, parity_out}, 32'h1);
`endif
      write_cycle(1'b0, 32'h000000A0);
      chk("hold_1", out, 32'h00000001);
      write_cycle(1'b1, 32'h000000A0);
      chk("write_A0", out, 32'h000000A0);
      write_cycle(1'b1, 32'h000000A0);
      chk("rewrite_same", out, 32'h000000A0);

      // Hold while data toggles every half-cycle.
      en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         newdata = 32'hFFFFFFFF;
         @(negedge clk);
         #1;
         newdata = 32'h0;
         @(posedge clk);
         #1;
         chk("toggle_hold", out, 32'h000000A0);
      end

      write_cycle(1'b1, 32'hFFFFFFFF);
      chk("write_all_ones", out, 32'hFFFFFFFF);

      // Reset colliding with a write.
      en      = 1'b1;
      newdata = 32'hDEADBEEF;
      reset   = 1'b1;
      @(posedge clk);
      #1;
      chk("collision_out", out, 32'h0);
`ifdef REG32_PARITY_EN
      chk("collision_parity", {31'h0, parity_out}, 32'h0);
`endif
      en = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      write_cycle(1'b0, 32'h00000007);
      chk("post_release_idle", out, 32'h0);
      write_cycle(1'b1, 32'h00000007);
      chk("write_7", out, 32'h00000007);
`ifdef REG32_PARITY_EN
      chk("parity_7", {31'h0, parity_out}, 32'h1);
`endif
      write_cycle(1'b1, 32'h00000003);
      chk("write_3", out, 32'h00000003);
`ifdef REG32_PARITY_EN
      chk("parity_3", {31'h0, parity_out}, 32'h0);
`endif
      write_cycle(1'b0, 32'hDEADBEEF);
      chk("hold_3", out, 32'h00000003);

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
